dma_job_sequencer: RTL and testbench

Queues DMA transfer descriptors and runs them back to back on the DMA controller. It drives the controller's custom-instruction configuration port: programs bus start, memory start, block size, burst size and control, then polls status until the transfer finishes. It sits between the CPU/pipeline producers (e.g. frame-tile fetch/writeback in the movement-detection path) and the single DMA controller. It frees the CPU from per-transfer register programming and polling.

---
 rtl/dma_job_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_dma_job_sequencer.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_job_sequencer.sv
// DMA job sequencer: queues transfer descriptors and runs them one after another on the DMA
// controller's configuration port. Each job writes bus start, memory start, block size,
// burst-1 and control, then polls status until the transfer finishes or fails.
//
// Ports:
//   clock, reset           clock; synchronous active-high reset
//   desc_*_i, desc_ready_o descriptor push interface (push = desc_valid_i && desc_ready_o)
//   err_clear_i            leave the halted state after a failed job
//   dma_*                  DMA custom-instruction configuration port
//   busy_o                 sequencer active or descriptors pending
//   job_done_o/job_error_o one-cycle pulses per finished/failed job
//   halted_o               waiting for err_clear_i after a failure
//   jobs_completed_o       wrapping count of job_done_o pulses
module dma_job_sequencer #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned START_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        desc_valid_i,
  output logic        desc_ready_o,
  input  logic [31:0] desc_bus_addr_i,
  input  logic [8:0]  desc_mem_addr_i,
  input  logic [9:0]  desc_block_size_i,
  input  logic [7:0]  desc_burst_i,
  input  logic        desc_dir_i,
  input  logic        err_clear_i,
  output logic        dma_valid_o,
  output logic        dma_we_o,
  output logic [2:0]  dma_cfg_o,
  output logic [31:0] dma_wdata_o,
  input  logic [31:0] dma_rdata_i,
  output logic        busy_o,
  output logic        job_done_o,
  output logic        job_error_o,
  output logic        halted_o,
  output logic [15:0] jobs_completed_o
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned TimerW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StCfg,
    StWaitStart,
    StWaitDone,
    StReport,
    StHalt
  } state_e;

  typedef struct packed {
    logic [31:0] bus_addr;
    logic [8:0]  mem_addr;
    logic [9:0]  block_size;
    logic [7:0]  burst;
    logic        dir;
  } desc_t;

  desc_t             fifo_q [DEPTH];
  logic [PtrW:0]     wr_ptr_q, rd_ptr_q;
  logic              full, empty, push, pop;
  desc_t             head, job_q;
  state_e            state_q, state_d;
  logic [2:0]        cfg_idx_q, cfg_idx_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [15:0]       jobs_q;
  logic [1:0]        status;
  logic              start_expired;
  logic              unused_rdata;

  assign status       = dma_rdata_i[1:0];
  assign unused_rdata = ^dma_rdata_i[31:2];

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                 (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign push  = desc_valid_i && !full;
  assign pop   = (state_q == StIdle) && !empty;
  assign head  = fifo_q[rd_ptr_q[PtrW-1:0]];

  // The current poll is the last one allowed before giving up on the start.
  assign start_expired = (timer_q == TimerW'(START_TIMEOUT - 1));

  // Descriptor storage needs no reset; the pointers define validity.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_q[wr_ptr_q[PtrW-1:0]] <= '{bus_addr:   desc_bus_addr_i,
                                      mem_addr:   desc_mem_addr_i,
                                      block_size: desc_block_size_i,
                                      burst:      desc_burst_i,
                                      dir:        desc_dir_i};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      job_q    <= '0;
      jobs_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + {{PtrW{1'b0}}, 1'b1};
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + {{PtrW{1'b0}}, 1'b1};
        job_q    <= head;
      end
      if (state_q == StReport) jobs_q <= jobs_q + 16'd1;
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      cfg_idx_q <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      cfg_idx_q <= cfg_idx_d;
      timer_q   <= timer_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cfg_idx_d = cfg_idx_q;
    timer_d   = timer_q;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          // A zero-size transfer never starts on the DMA, so skip it entirely.
          if (head.block_size == '0) begin
            state_d = StReport;
          end else begin
            state_d   = StCfg;
            cfg_idx_d = 3'd1;
          end
        end
      end
      StCfg: begin
        if (cfg_idx_q == 3'd5) begin
          state_d = StWaitStart;
          timer_d = '0;
        end else begin
          cfg_idx_d = cfg_idx_q + 3'd1;
        end
      end
      StWaitStart: begin
        // Only busy advances; a stale idle/error status from the last job is ignored.
        if (status == 2'd1) begin
          state_d = StWaitDone;
        end else begin
          timer_d = timer_q + TimerW'(1);
          if (start_expired) state_d = StHalt;
        end
      end
      StWaitDone: begin
        if (status == 2'd0) begin
          state_d = StReport;
        end else if (status == 2'd2) begin
          state_d = StHalt;
        end
      end
      StReport: state_d = StIdle;
      StHalt: begin
        if (err_clear_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    dma_valid_o = 1'b0;
    dma_we_o    = 1'b0;
    dma_cfg_o   = 3'd0;
    dma_wdata_o = 32'd0;
    job_done_o  = 1'b0;
    job_error_o = 1'b0;
    unique case (state_q)
      StCfg: begin
        dma_valid_o = 1'b1;
        dma_we_o    = 1'b1;
        dma_cfg_o   = cfg_idx_q;
        case (cfg_idx_q)
          3'd1:    dma_wdata_o = job_q.bus_addr;
          3'd2:    dma_wdata_o = 32'(job_q.mem_addr);
          3'd3:    dma_wdata_o = 32'(job_q.block_size);
          3'd4:    dma_wdata_o = 32'(job_q.burst);
          3'd5:    dma_wdata_o = job_q.dir ? 32'd1 : 32'd2;
          default: dma_wdata_o = 32'd0;
        endcase
      end
      StWaitStart: begin
        dma_valid_o = 1'b1;
        dma_cfg_o   = 3'd5;
        job_error_o = (status != 2'd1) && start_expired;
      end
      StWaitDone: begin
        dma_valid_o = 1'b1;
        dma_cfg_o   = 3'd5;
        job_error_o = (status == 2'd2);
      end
      StReport: job_done_o = 1'b1;
      default: ;
    endcase
  end

  assign desc_ready_o     = !full;
  assign busy_o           = (state_q != StIdle) || !empty;
  assign halted_o         = (state_q == StHalt);
  assign jobs_completed_o = jobs_q;

endmodule

// File: tb/tb_dma_job_sequencer.sv
// Testbench for dma_job_sequencer: a behavioural DMA model answers the configuration port,
// stimulus pushes expected writes/events into scoreboard queues, and a monitor compares
// them as the sequencer produces them.
module tb_dma_job_sequencer;
  localparam int unsigned DEPTH         = 4;
  localparam int unsigned START_TIMEOUT = 15;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        desc_valid = 1'b0;
  logic        desc_ready;
  logic [31:0] desc_bus_addr = '0;
  logic [8:0]  desc_mem_addr = '0;
  logic [9:0]  desc_block_size = '0;
  logic [7:0]  desc_burst = '0;
  logic        desc_dir = 1'b0;
  logic        err_clear = 1'b0;
  logic        dma_valid, dma_we;
  logic [2:0]  dma_cfg;
  logic [31:0] dma_wdata, dma_rdata;
  logic        busy, job_done, job_error, halted;
  logic [15:0] jobs_completed;

  always #5 clock = ~clock;

  dma_job_sequencer #(.DEPTH(DEPTH), .START_TIMEOUT(START_TIMEOUT)) dut (
    .clock            (clock),
    .reset            (reset),
    .desc_valid_i     (desc_valid),
    .desc_ready_o     (desc_ready),
    .desc_bus_addr_i  (desc_bus_addr),
    .desc_mem_addr_i  (desc_mem_addr),
    .desc_block_size_i(desc_block_size),
    .desc_burst_i     (desc_burst),
    .desc_dir_i       (desc_dir),
    .err_clear_i      (err_clear),
    .dma_valid_o      (dma_valid),
    .dma_we_o         (dma_we),
    .dma_cfg_o        (dma_cfg),
    .dma_wdata_o      (dma_wdata),
    .dma_rdata_i      (dma_rdata),
    .busy_o           (busy),
    .job_done_o       (job_done),
    .job_error_o      (job_error),
    .halted_o         (halted),
    .jobs_completed_o (jobs_completed)
  );

  // How the DMA behaves for one started transfer.
  typedef struct {
    int unsigned busy;   // cycles reporting busy
    bit          err;    // end with status 2 instead of 0
    bit          never;  // never report busy
  } plan_t;

  typedef struct {
    logic [2:0]  cfg;
    logic [31:0] data;
  } wr_t;

  wr_t   exp_wr[$];
  bit    exp_ev[$];  // 0 = job_done, 1 = job_error
  plan_t plan_q[$];
  int    exp_done_cnt = 0;
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    last_wr_cyc = -10;
  int    last_ctl_cyc = 0;
  int    last_err_cyc = 0;
  int    prev_done = 0;
  bit    have_prev = 1'b0;
  bit    gap_chk = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    total++;
    bad++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // DMA model: status goes busy two cycles after the control write, then idle or error.
  logic [1:0] st;
  int         lat;
  int         busy_left;
  plan_t      cur;
  assign dma_rdata = {30'd0, st};

  always @(posedge clock) begin
    if (reset) begin
      st        <= 2'd0;
      lat       <= 0;
      busy_left <= 0;
    end else if (dma_valid && dma_we && dma_cfg == 3'd5) begin
      if (plan_q.size() != 0) cur <= plan_q.pop_front();
      else cur.never <= 1'b1;
      lat <= 1;
    end else if (lat == 1) begin
      lat <= 0;
      if (!cur.never) begin
        st        <= 2'd1;
        busy_left <= cur.busy;
      end
    end else if (st == 2'd1 && busy_left > 0) begin
      if (busy_left == 1) st <= cur.err ? 2'd2 : 2'd0;
      busy_left <= busy_left - 1;
    end
  end

  // Monitor
  initial begin
    wr_t w;
    bit  e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (dma_valid && dma_we) begin
          if (exp_wr.size() == 0) begin
            fail_now("dma_write", "unexpected configuration write");
          end else begin
            w = exp_wr.pop_front();
            check("dma_cfg", dma_cfg, w.cfg);
            check("dma_wdata", dma_wdata, w.data);
            if (dma_cfg != 3'd1) check("write_spacing", cyc - last_wr_cyc, 1);
          end
          last_wr_cyc = cyc;
          if (dma_cfg == 3'd5) last_ctl_cyc = cyc;
        end
        if (job_done || job_error) begin
          if (job_done && job_error) begin
            fail_now("job_event", "done and error in the same cycle");
          end else if (exp_ev.size() == 0) begin
            fail_now("job_event", "unexpected job event");
          end else begin
            e = exp_ev.pop_front();
            check("job_kind_error", job_error, e);
          end
          if (job_error) last_err_cyc = cyc;
          if (job_done) begin
            if (gap_chk && have_prev) check("done_gap_ge9", (cyc - prev_done) >= 9, 1);
            prev_done = cyc;
            have_prev = 1'b1;
          end
        end
      end
    end
  end

  task automatic exp_write(input logic [2:0] cfg, input logic [31:0] data);
    wr_t w;
    w.cfg  = cfg;
    w.data = data;
    exp_wr.push_back(w);
  endtask

  // Reference: a nonzero job is five field writes then the planned outcome; zero is a done.
  task automatic push_desc(input logic [31:0] ba, input logic [8:0] ma, input logic [9:0] sz,
                           input logic [7:0] bu, input logic dir, input plan_t pl,
                           input bit exp_accept);
    check("desc_ready", desc_ready, exp_accept);
    desc_valid      = 1'b1;
    desc_bus_addr   = ba;
    desc_mem_addr   = ma;
    desc_block_size = sz;
    desc_burst      = bu;
    desc_dir        = dir;
    if (exp_accept) begin
      if (sz != 0) begin
        exp_write(3'd1, ba);
        exp_write(3'd2, {23'd0, ma});
        exp_write(3'd3, {22'd0, sz});
        exp_write(3'd4, {24'd0, bu});
        exp_write(3'd5, dir ? 32'd1 : 32'd2);
        plan_q.push_back(pl);
        exp_ev.push_back(pl.err || pl.never);
        if (!(pl.err || pl.never)) exp_done_cnt++;
      end else begin
        exp_ev.push_back(1'b0);
        exp_done_cnt++;
      end
    end
    tick();
    desc_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < max) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) fail_now(name, "timed out waiting for idle");
  endtask

  task automatic wait_halt(input string name, input int max);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    if (halted !== 1'b1) fail_now(name, "timed out waiting for halt");
  endtask

  task automatic drain_check(input string name);
    check({name, "_jobs_completed"}, jobs_completed, 16'(exp_done_cnt));
    check({name, "_pending_writes"}, exp_wr.size(), 0);
    check({name, "_pending_events"}, exp_ev.size(), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_desc_ready"}, desc_ready, 1);
    check({name, "_busy"}, busy, 0);
    check({name, "_halted"}, halted, 0);
    check({name, "_job_done"}, job_done, 0);
    check({name, "_job_error"}, job_error, 0);
    check({name, "_jobs_completed"}, jobs_completed, 0);
    check({name, "_dma_valid"}, dma_valid, 0);
    check({name, "_dma_we"}, dma_we, 0);
    check({name, "_dma_cfg"}, dma_cfg, 0);
    check({name, "_dma_wdata"}, dma_wdata, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    plan_t p, pe, pt;
    int    n_dv;
    int    n;
    tick();
    tick();
    tick();
    reset = 1'b0;
    check_reset_outputs("reset");

    // Single read job from the worked example.
    p.busy = 6; p.err = 0; p.never = 0;
    push_desc(32'h1000_0000, 9'h010, 10'd8, 8'd3, 1'b1, p, 1'b1);
    wait_idle("single", 200);
    check("single_jobs_completed", jobs_completed, 1);
    drain_check("single");

    // Zero-size job: done two cycles after the push, DMA untouched; then a normal write job.
    push_desc(32'h0000_000A, 9'h001, 10'd0, 8'd0, 1'b0, p, 1'b1);
    check("zero_pop_no_dma", dma_valid, 0);
    tick();
    check("zero_done_at_2", job_done, 1);
    check("zero_report_no_dma", dma_valid, 0);
    tick();
    p.busy = 4;
    push_desc(32'h2000_0040, 9'h1FF, 10'd1023, 8'hFF, 1'b0, p, 1'b1);
    err_clear = 1'b1;  // must be ignored outside the halted state
    wait_idle("zero_then_valid", 200);
    err_clear = 1'b0;
    drain_check("zero_then_valid");

    // Error in WAIT_DONE with a descriptor queued behind it; fill the FIFO while halted.
    pe.busy = 3; pe.err = 1; pe.never = 0;
    p.busy = 2;
    push_desc(32'h3000_0000, 9'h005, 10'd16, 8'd7, 1'b1, pe, 1'b1);
    push_desc(32'h3000_1000, 9'h006, 10'd17, 8'd1, 1'b0, p, 1'b1);
    wait_halt("err_done", 200);
    check("err_halted", halted, 1);
    check("err_busy_with_queue", busy, 1);
    n_dv = 0;
    for (int i = 0; i < 8; i++) begin
      if (dma_valid) n_dv++;
      tick();
    end
    check("halt_no_dma", n_dv, 0);
    check("halt_queue_not_popped", exp_wr.size(), 5);
    for (int i = 0; i < 3; i++) begin
      p.busy = 1 + i;
      push_desc(32'h4000_0000 + 32'(i * 64), 9'(i + 32), 10'(i + 3), 8'(i), 1'(i), p, 1'b1);
    end
    check("full_ready_low", desc_ready, 0);
    push_desc(32'hDEAD_BEEF, 9'h0AA, 10'd5, 8'd2, 1'b1, p, 1'b0);
    check("still_halted", halted, 1);
    gap_chk = 1'b1;
    have_prev = 1'b0;
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("cleared_halt", halted, 0);
    wait_idle("after_clear", 500);
    gap_chk = 1'b0;
    drain_check("after_clear");

    // DMA never reports busy: error after START_TIMEOUT polls.
    pt.busy = 1; pt.err = 0; pt.never = 1;
    push_desc(32'h5000_0000, 9'h100, 10'd12, 8'd3, 1'b1, pt, 1'b1);
    wait_halt("timeout", 200);
    check("timeout_cycles", last_err_cyc - last_ctl_cyc, START_TIMEOUT);
    check("timeout_halted", halted, 1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("timeout_cleared", halted, 0);
    check("timeout_idle", busy, 0);
    drain_check("timeout");

    // Randomized bursts of descriptors with occasional DMA errors.
    for (int r = 0; r < 10; r++) begin
      int     k;
      plan_t  pr;
      logic [9:0] sz;
      k = $urandom_range(1, DEPTH);
      for (int j = 0; j < k; j++) begin
        pr.busy  = $urandom_range(1, 5);
        pr.err   = ($urandom_range(0, 7) == 0);
        pr.never = 1'b0;
        sz = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
        push_desc($urandom, 9'($urandom), sz, 8'($urandom), 1'($urandom), pr, 1'b1);
      end
      n = 0;
      while (n < 2000) begin
        if (halted === 1'b1) begin
          err_clear = 1'b1;
          tick();
          err_clear = 1'b0;
        end else if (busy === 1'b0) begin
          break;
        end else begin
          tick();
        end
        n++;
      end
      if (busy !== 1'b0) fail_now("random", "timed out waiting for idle");
      drain_check("random");
    end

    // Reset during WAIT_DONE with two jobs queued.
    p.busy = 40;
    push_desc(32'h6000_0000, 9'h011, 10'd64, 8'd15, 1'b1, p, 1'b1);
    p.busy = 2;
    push_desc(32'h6000_1000, 9'h012, 10'd8, 8'd1, 1'b0, p, 1'b1);
    push_desc(32'h6000_2000, 9'h013, 10'd9, 8'd2, 1'b1, p, 1'b1);
    repeat (18) tick();
    check("pre_reset_in_poll", dma_valid, 1);
    reset = 1'b1;
    tick();
    exp_wr.delete();
    exp_ev.delete();
    plan_q.delete();
    exp_done_cnt = 0;
    check_reset_outputs("midjob_reset");
    reset = 1'b0;
    repeat (40) tick();
    check("post_reset_idle", busy, 0);
    drain_check("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
